fmul_round_stage: RTL and testbench

- IEEE-754 single-precision multiply sequencer for the shader FPU.
- Unpacks two fp32 operands and drives 24-bit mantissas to an external unsigned 24x24 lpm_mult instance.
- Carries sign, exponent and special-case sideband through a delay line matched to the multiplier latency.
- Consumes the 48-bit product, then normalizes, rounds to nearest-even, applies special cases and registers the fp32 result with flags.

---
 rtl/fmul_round_stage.sv | 170 +++++++++++++++++
 tb/tb_fmul_round_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_round_stage.sv
// fp32 multiply sequencer: unpack operands, feed an external 24x24 multiplier, normalize/round/pack its product.
// Latency MULT_LATENCY+1 enabled cycles from in_valid to out_valid; one result per enabled cycle, bubbles preserved.
// No backpressure: clken=0 freezes every register (and the external multiplier), so results stretch but never drop.
//
// Ports:
//   clock, aclr, clken     - clock, async active-high clear, stage enable (shared with the multiplier)
//   in_valid, a, b         - fp32 operands
//   mant_a, mant_b         - {hidden, frac} to multiplier dataa/datab, zero for zero/denormal operands
//   prod                   - 48-bit multiplier result, MULT_LATENCY cycles after mant_a/mant_b
//   out_valid, result      - registered fp32 product
//   flag_invalid/overflow/underflow/inexact - per-result exception flags, meaningful with out_valid
module fmul_round_stage #(
    parameter int MULT_LATENCY = 2,
    parameter bit FLUSH_DENORM = 1
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clken,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [23:0] mant_a,
    output logic [23:0] mant_b,
    input  logic [47:0] prod,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    // Only flush-to-zero behaviour and the multiplier's supported depths are implemented.
    if (MULT_LATENCY < 1 || MULT_LATENCY > 8) begin : g_bad_latency
        $error("fmul_round_stage: MULT_LATENCY must be 1..8");
    end
    if (FLUSH_DENORM != 1'b1) begin : g_bad_flush
        $error("fmul_round_stage: FLUSH_DENORM must be 1");
    end

    // Sideband travelling alongside the multiplier pipeline.
    typedef struct packed {
        logic       vld;
        logic       sign;
        logic [9:0] esum;   // ea+eb-127, two's complement
        logic       nan;    // either operand NaN
        logic       inv;    // inf * zero
        logic       inf;    // either operand infinite
        logic       zero;   // either operand zero/denormal
    } sb_t;

    // ---------------- unpack / classify ----------------
    logic [7:0] ea, eb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    sb_t        sb_in;

    always_comb begin
        ea     = a[30:23];
        eb     = b[30:23];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
        mant_a = a_zero ? 24'd0 : {1'b1, a[22:0]};
        mant_b = b_zero ? 24'd0 : {1'b1, b[22:0]};

        sb_in.vld  = in_valid;
        sb_in.sign = a[31] ^ b[31];
        sb_in.esum = {2'b00, ea} + {2'b00, eb} - 10'd127;
        sb_in.nan  = a_nan | b_nan;
        sb_in.inv  = (a_inf & b_zero) | (b_inf & a_zero);
        sb_in.inf  = a_inf | b_inf;
        sb_in.zero = a_zero | b_zero;
    end

    // ---------------- sideband delay line ----------------
    sb_t sb_q [MULT_LATENCY];

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < MULT_LATENCY; i++) sb_q[i] <= '0;
        end else if (clken) begin
            sb_q[0] <= sb_in;
            for (int i = 1; i < MULT_LATENCY; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    // ---------------- normalize / round / pack ----------------
    sb_t         sb;
    logic [22:0] m, m_r;
    logic        g, st, rnd, carry;
    logic [10:0] e_n, e_r;      // two's complement, wide enough for esum+2
    logic [31:0] nxt_result;
    logic        nxt_inv, nxt_ovf, nxt_udf, nxt_inx;

    always_comb begin
        sb = sb_q[MULT_LATENCY-1];

        if (prod[47]) begin
            m  = prod[46:24];
            g  = prod[23];
            st = |prod[22:0];
        end else begin
            m  = prod[45:23];
            g  = prod[22];
            st = |prod[21:0];
        end
        e_n = {sb.esum[9], sb.esum} + {10'd0, prod[47]};

        // Nearest-even: round up on more than half, or exactly half with odd lsb.
        rnd          = g & (st | m[0]);
        {carry, m_r} = {1'b0, m} + {23'd0, rnd};
        e_r          = e_n + {10'd0, carry};   // carry-out leaves m_r = 0, i.e. 1.0 at the next exponent

        nxt_result = {sb.sign, e_r[7:0], m_r};
        nxt_inv    = 1'b0;
        nxt_ovf    = 1'b0;
        nxt_udf    = 1'b0;
        nxt_inx    = g | st;

        if ($signed(e_r) >= 11'sd255) begin
            nxt_result = {sb.sign, 8'hFF, 23'd0};
            nxt_ovf    = 1'b1;
            nxt_inx    = 1'b1;
        end else if ($signed(e_r) <= 11'sd0) begin
            nxt_result = {sb.sign, 31'd0};
            nxt_udf    = 1'b1;
        end

        // Special classes override the arithmetic path; prod is meaningless for them.
        if (sb.nan || sb.inv || sb.inf || sb.zero) begin
            nxt_ovf = 1'b0;
            nxt_udf = 1'b0;
            nxt_inx = 1'b0;
            if (sb.nan) begin
                nxt_result = 32'h7FC0_0000;
            end else if (sb.inv) begin
                nxt_result = 32'h7FC0_0000;
                nxt_inv    = 1'b1;
            end else if (sb.inf) begin
                nxt_result = {sb.sign, 8'hFF, 23'd0};
            end else begin
                nxt_result = {sb.sign, 31'd0};
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            out_valid      <= 1'b0;
            result         <= 32'd0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (clken) begin
            out_valid <= sb.vld;
            if (sb.vld) begin
                result         <= nxt_result;
                flag_invalid   <= nxt_inv;
                flag_overflow  <= nxt_ovf;
                flag_underflow <= nxt_udf;
                flag_inexact   <= nxt_inx;
            end
        end
    end

endmodule

// File: tb/tb_fmul_round_stage.sv
// Bench for fmul_round_stage with a behavioural multiplier, a queue of expected
// results and an independent monitor that pops and compares on every fresh result.
module tb_fmul_round_stage;
    localparam int L = 2;

    logic        clock = 1'b0;
    logic        aclr = 1'b0;
    logic        clken = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [23:0] mant_a, mant_b;
    logic [47:0] prod;
    logic        out_valid;
    logic [31:0] result;
    logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;

    fmul_round_stage #(.MULT_LATENCY(L), .FLUSH_DENORM(1'b1)) dut (
        .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid),
        .a(a), .b(b), .mant_a(mant_a), .mant_b(mant_b), .prod(prod),
        .out_valid(out_valid), .result(result),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
    );

    always #5 clock = ~clock;

    // External pipelined multiplier.
    logic [47:0] mpipe [L];
    always @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < L; i++) mpipe[i] <= 48'd0;
        end else if (clken) begin
            mpipe[0] <= {24'd0, mant_a} * {24'd0, mant_b};
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign prod = mpipe[L-1];

    int   en_cnt = 0;   // number of enabled clock edges so far
    logic adv = 1'b0;   // last edge was enabled
    always @(posedge clock) begin
        adv <= clken;
        if (clken) en_cnt <= en_cnt + 1;
    end

    typedef struct {
        logic [35:0] val;   // {result, invalid, overflow, underflow, inexact}
        int          due;   // en_cnt value when the result must appear
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded remainder to one half.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        int ex, ey, sh, e;
        bit zx, zy, ix, iy, nx, ny, s;
        longint unsigned p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        if (nx || ny) return {32'h7FC00000, 4'b0000};
        if ((ix && zy) || (iy && zx)) return {32'h7FC00000, 4'b1000};
        if (ix || iy) return {s, 8'hFF, 23'd0, 4'b0000};
        if (zx || zy) return {s, 31'd0, 4'b0000};
        p    = (64'h800000 | 64'(x[22:0])) * (64'h800000 | 64'(y[22:0]));
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        e = ex + ey - 127 + (sh - 23);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
        if (e <= 0) return {s, 31'd0, 3'b001, rem != 0};
        return {s, e[7:0], q[22:0], 3'b000, rem != 0};
    endfunction

    // Called just after a rising edge; the op is sampled on the next edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        exp_t t;
        a = x;
        b = y;
        in_valid = 1'b1;
        clken = 1'b1;
        t.val = model(x, y);
        t.due = en_cnt + 1 + L;
        sbq.push_back(t);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic en);
        in_valid = 1'b0;
        clken = en;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
        clken = 1'b1;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0: r[30:0] = 31'd0;
            1: r[30:23] = 8'd0;
            2: r[30:0] = 31'h7F800000;
            3: begin r[30:23] = 8'hFF; r[22] = 1'b1; end
            4, 5, 6, 7: r[30:23] = 8'($urandom_range(100, 154));
            default: r[30:23] = 8'($urandom_range(1, 254));
        endcase
        return r;
    endfunction

    // Monitor: a fresh result follows every enabled edge with out_valid; during a stall it must hold.
    logic [35:0] last_exp;
    bit          have_last = 1'b0;
    always @(negedge clock) begin
        if (!aclr && out_valid) begin
            if (adv) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", {28'd0, result, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 64'd0);
                end else begin
                    exp_t t;
                    t = sbq.pop_front();
                    chk("result_flags", {28'd0, result, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, {28'd0, t.val});
                    chk("latency", 64'(en_cnt), 64'(t.due));
                    last_exp  = t.val;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk("stall_hold", {28'd0, result, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, {28'd0, last_exp});
            end
        end
    end

    initial begin
        #1 aclr = 1'b1;
        #10;
        chk("reset_state", {27'd0, out_valid, result, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 64'd0);
        @(posedge clock);
        #1 aclr = 1'b0;

        // Combinational unpack.
        a = 32'h3FC00000; b = 32'h00400000;
        #1;
        chk("mant_a_normal", 64'(mant_a), 64'h00C00000);
        chk("mant_b_denorm", 64'(mant_b), 64'd0);
        a = 32'h7F800000; b = 32'h80000000;
        #1;
        chk("mant_a_inf", 64'(mant_a), 64'h00800000);
        chk("mant_b_zero", 64'(mant_b), 64'd0);
        @(posedge clock);
        #1;

        // Directed cases, isolated.
        issue(32'h3FC00000, 32'h40000000); idle(L + 2, 1'b1);
        chk("directed_3p0", 64'(model(32'h3FC00000, 32'h40000000)), {28'd0, 32'h40400000, 4'b0000});
        issue(32'h3F800001, 32'h3F800001); idle(L + 2, 1'b1);
        issue(32'h7F000000, 32'h40000000); idle(L + 2, 1'b1);
        issue(32'hFF000000, 32'h40000000); idle(L + 2, 1'b1);
        issue(32'h00800000, 32'h3F000000); idle(L + 2, 1'b1);
        issue(32'h7F800000, 32'h00000000); idle(L + 2, 1'b1);
        issue(32'h7FC00001, 32'h3F800000); idle(L + 2, 1'b1);
        issue(32'h7F800000, 32'hBF800000); idle(L + 2, 1'b1);
        issue(32'h3FFFFFFF, 32'h3FFFFFFF); idle(L + 2, 1'b1);

        // Back-to-back with a two-cycle stall after the second op.
        issue(32'h3FC00000, 32'h40000000);
        issue(32'h3F800001, 32'h3F800001);
        idle(2, 1'b0);
        issue(32'h40400000, 32'h40A00000);
        issue(32'hC0000000, 32'h3E800000);
        idle(L + 3, 1'b1);

        // Reset with three ops in flight.
        issue(32'h3FC00000, 32'h40000000);
        issue(32'h40000000, 32'h40000000);
        issue(32'h40400000, 32'h40400000);
        #2 aclr = 1'b1;
        #1;
        chk("aclr_immediate", {31'd0, out_valid, result}, 64'd0);
        sbq.delete();
        aclr = 1'b0;
        idle(L + 3, 1'b1);
        issue(32'h40A00000, 32'h3F000000);
        idle(L + 3, 1'b1);

        // Randomized traffic with bubbles and stalls.
        for (int i = 0; i < 400; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 1) idle(gap - 1, 1'($urandom_range(0, 1)));
            issue(rnd_op(), rnd_op());
        end
        idle(L + 4, 1'b1);
        chk("queue_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
